// File: rtl/sumador_pkg.sv
// sumador_pkg: sequencer state type and index sizing for the multiword adder
package sumador_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  function automatic int idx_width(input int words);
    return words > 1 ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/sumador_parametrizable.sv
// sumador_parametrizable: WIDTH-bit adder with carry chain and two's-complement overflow flag
module sumador_parametrizable #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             carry_out,
  output logic             overflow
);
  assign {carry_out, S} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
  assign overflow = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
endmodule

// File: rtl/sumador_multipalabra_ctrl.sv
// sumador_multipalabra_ctrl: word-serial multi-precision add/sub on one shared WIDTH-bit adder
module sumador_multipalabra_ctrl
  import sumador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [WIDTH*WORDS-1:0] A,
  input  logic [WIDTH*WORDS-1:0] B,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] S,
  output logic                   carry_out,
  output logic                   overflow
);
  localparam int IW = idx_width(WORDS);
  seq_state_t state, nxt;
  logic [IW-1:0] idx;
  logic [WIDTH*WORDS-1:0] a_q, b_q;
  logic c_q, accept, last, add_co, add_ov;
  logic [WIDTH-1:0] add_s;
  sumador_parametrizable #(.WIDTH(WIDTH)) u_add (
    .A(a_q[idx*WIDTH +: WIDTH]),
    .B(b_q[idx*WIDTH +: WIDTH]),
    .Cin(c_q),
    .S(add_s),
    .carry_out(add_co),
    .overflow(add_ov)
  );
  always_comb begin
    ready = state == IDLE || state == DONE;
    busy = state == RUN;
    done = state == DONE;
    accept = start && ready;
    last = idx == IW'(WORDS - 1);
    nxt = accept ? RUN : busy ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      S <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      idx <= '0;
      c_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_q <= A;
        b_q <= op_sub ? ~B : B;
        c_q <= op_sub;
        idx <= '0;
      end else if (busy) begin
        S[idx*WIDTH +: WIDTH] <= add_s;
        c_q <= add_co;
        idx <= last ? '0 : idx + 1'b1;
        if (last) begin
          carry_out <= add_co;
          overflow <= add_ov;
        end
      end
    end
  end
endmodule

// File: tb/tb_sumador_multipalabra_ctrl.sv
// tb_sumador_multipalabra_ctrl: scoreboard bench for the word-serial multiword adder
module tb_sumador_multipalabra_ctrl;
  localparam int WIDTH = 4;
  localparam int WORDS = 4;
  localparam int N = WIDTH * WORDS;
  typedef struct {
    logic [N-1:0] s;
    logic co;
    logic ov;
  } exp_t;
  logic clk = 1'b0, rst_n, start, op_sub, ready, busy, done, carry_out, overflow;
  logic [N-1:0] A, B, S;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0, done_cnt = 0, busy_run = 0, cyc = 0, acc_cyc = 0;
  sumador_multipalabra_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .S(S), .carry_out(carry_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    logic [N:0] f;
    exp_t r;
    f = sub ? {1'b0, a} + {1'b0, ~b} + (N+1)'(1) : {1'b0, a} + {1'b0, b};
    r.s = f[N-1:0];
    r.co = f[N];
    r.ov = sub ? (a[N-1] != b[N-1]) && (r.s[N-1] != a[N-1])
               : (a[N-1] == b[N-1]) && (r.s[N-1] != a[N-1]);
    return r;
  endfunction
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (!done) busy_run = 0;
    if (done) begin
      done_cnt++;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("S", 32'(S), 32'(e.s));
        chk("carry_out", 32'(carry_out), 32'(e.co));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("latency", 32'(cyc - acc_cyc), WORDS);
        chk("busy_cycles", 32'(busy_run), WORDS);
        chk("ready_in_done", 32'(ready), 1);
      end
      busy_run = 0;
    end
  end
  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input bit push);
    A = a;
    B = b;
    op_sub = sub;
    start = 1'b1;
    if (push) sb.push_back(model(a, b, sub));
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask
  task automatic wait_done();
    int n = 0;
    int c0 = done_cnt;
    while (done_cnt == c0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_timeout", 32'(n < 40), 1);
  endtask
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    drive(a, b, sub, 1'b1);
    wait_done();
  endtask
  initial begin
    int n;
    logic [N-1:0] s_hold;
    logic co_hold, ov_hold;
    rst_n = 1'b0;
    start = 1'b0;
    op_sub = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_S", 32'(S), 0);
    chk("rst_co", 32'(carry_out), 0);
    chk("rst_ov", 32'(overflow), 0);
    op(16'h00FF, 16'h0001, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'h0005, 16'h0007, 1'b1);
    op(16'h8000, 16'h0001, 1'b1);
    drive(16'h1234, 16'h1111, 1'b0, 1'b1);
    A = 16'hFFFF;
    B = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_done_timeout", 32'(n < 20), 1);
    drive(16'h0001, 16'h0001, 1'b0, 1'b1);
    chk("b2b_busy", 32'(busy), 1);
    wait_done();
    drive(16'h0ABC, 16'h0123, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    n = done_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_S", 32'(S), 0);
    chk("abort_done", 32'(done), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'(n));
    op(16'h0003, 16'h0004, 1'b0);
    for (int i = 0; i < 6; i++) op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
    op(16'h7FFF, 16'h8000, 1'b1);
    s_hold = S;
    co_hold = carry_out;
    ov_hold = overflow;
    n = done_cnt;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("hold_S", 32'(S), 32'(s_hold));
      chk("hold_co", 32'(carry_out), 32'(co_hold));
      chk("hold_ov", 32'(overflow), 32'(ov_hold));
      chk("hold_ready", 32'(ready), 1);
      chk("hold_done", 32'(done), 0);
    end
    chk("hold_no_done", 32'(done_cnt), 32'(n));
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
